alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Upstream operand/opcode entry stage for the N-bit board ALU.
- Captures operand A, operand B, then opcode+carry-in from board switches on successive debounced presses of an active-low enter button.
- Drives the combinational ALU from registers, then latches its result and flags for display.
- Replaces direct switch-to-ALU wiring so operands are stable and results are held.

Parameters:
- N, 4, operand/result width (matches ALU N).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a button level change (sim value; board build overrides).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- data_sw  input  N  operand switches.
- op_sw  input  4  opcode switches, active-high encoding.
- cin_sw  input  1  carry-in switch.
- enter_btn_n  input  1  raw enter button, active-low, asynchronous/bouncy.
- clear_btn_n  input  1  raw clear button, active-low, asynchronous/bouncy.
- alu_a  output  N  registered operand A to ALU.
- alu_b  output  N  registered operand B to ALU.
- alu_sel_n  output  4  registered opcode, inverted (ALU selector is active-low).
- alu_cin  output  1  registered carry-in.
- alu_result  input  N  ALU result.
- alu_neg, alu_zero, alu_cout, alu_ovf  input  1 each  ALU flags.
- res_q  output  N  latched result.
- flags_q  output  4  latched flags {ovf,cout,zero,neg} (bit3..bit0).
- res_valid  output  1  high while in SHOW.
- phase  output  2  state code for LEDs.
- err_q  output  1  invalid-opcode indicator.

Behaviour:
- Reset (async, rst_n=0):
  - state=GET_A.
  - alu_a, alu_b, alu_cin, res_q, flags_q, err_q all 0.
  - alu_sel_n=4'b1111 (opcode 0000).
  - res_valid=0.
  - Debouncer counters cleared; debounced levels = released (1).
- Buttons:
  - Each raw button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current level; any mismatch restarts the count.
  - A press is a 1-cycle pulse on the debounced 1->0 transition. Release produces no event.
  - Holding the button produces exactly one pulse.
- FSM states/encoding:
  - GET_A=0: on enter pulse, alu_a<=data_sw, go GET_B.
  - GET_B=1: on enter pulse, alu_b<=data_sw, go GET_OP.
  - GET_OP=2: on enter pulse:
    - If op_sw<=4'b1001: alu_sel_n<=~op_sw, alu_cin<=cin_sw, err_q<=0, go EXEC.
    - If op_sw is 1010..1111: err_q<=1, remain in GET_OP, ALU registers unchanged.
  - EXEC (internal, phase=2): exactly one cycle, so ALU inputs settle. On exit, res_q<=alu_result, flags_q<={alu_ovf,alu_cout,alu_zero,alu_neg}, go SHOW.
  - SHOW=3: res_valid=1. On enter pulse, go GET_A; res_q/flags_q hold until overwritten.
- Latency: the press pulse on the GET_OP cycle, then EXEC, then res_valid=1 on the 2nd clock after that pulse.
- Clear pulse, any state: go GET_A; zero alu_a, alu_b, alu_cin, res_q, flags_q, err_q; alu_sel_n=1111.
- Clear and enter pulses in the same cycle: clear wins, enter is ignored.
- Enter pulse during EXEC: ignored (not queued).
- data_sw changes between presses have no effect on held registers.
- Reset asserted mid-sequence: immediate return to reset values, no partial capture.
- Opcode map (ALU, active-high before inversion):
  - 0000 add, 0001 sub, 0010 not, 0011 and, 0100 or, 0101 xor.
  - 0110 srl, 0111 sll, 1000 sra, 1001 sla.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum (GET_A, GET_B, GET_OP, EXEC, SHOW).
  - opcode localparams (OP_ADD..OP_SLA) and OP_MAX=4'b1001.
  - flag bit indices (FLG_NEG=0, FLG_ZERO=1, FLG_COUT=2, FLG_OVF=3).
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_n_raw, press_pulse), instantiated twice.

Test Plan:
- Add: press sequence data_sw=0001, then 1010, then op_sw=0000 with cin_sw=1, each press held 3*DEBOUNCE_CYCLES -> alu_a=0001, alu_b=1010, alu_sel_n=1111, alu_cin=1. Model ALU returns 1100 -> res_q=1100, flags_q[2]=0, res_valid=1 exactly 2 cycles after the third press pulse.
- Shift: A=1011, B=0001, op=1000 -> alu_sel_n=0111; with the real ALU instantiated, res_q=1101 and phase=3.
- Invalid opcode: op_sw=1100 in GET_OP -> err_q=1, phase stays 2, alu_sel_n unchanged. Then op_sw=0011 -> err_q=0, EXEC entered.
- Bounce rejection: enter_btn_n low for DEBOUNCE_CYCLES-2 cycles, high, repeated 5 times -> no capture, state unchanged. One stable 40-cycle hold -> exactly one pulse and one state advance.
- Clear priority: in GET_OP with A and B loaded, assert both buttons so their pulses coincide -> phase=0, alu_a=alu_b=0, err_q=0.
- Async reset in SHOW: drop rst_n off-edge -> all outputs at reset values before the next clk edge. Release -> GET_A accepts a new press normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operand/opcode sequencer.
//   - seq_state_e : sequencer FSM states
//   - OP_*        : ALU opcodes (active-high, before inversion onto alu_sel_n)
//   - FLG_*       : bit positions of the latched flags vector
//   - op_is_valid : opcode legality check
//   - phase_code  : LED phase code for a given state
package alu_seq_pkg;

    // GET_A..SHOW carry their LED phase code in the low two bits. EXEC sits
    // outside that range and reports as GET_OP.
    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        SHOW   = 3'd3,
        EXEC   = 3'd4
    } seq_state_e;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLA = 4'b1001;
    localparam logic [3:0] OP_MAX = OP_SLA;

    localparam int unsigned FLG_NEG  = 0;
    localparam int unsigned FLG_ZERO = 1;
    localparam int unsigned FLG_COUT = 2;
    localparam int unsigned FLG_OVF  = 3;

    function automatic logic op_is_valid(input logic [3:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR,
            OP_XOR, OP_SRL, OP_SLL, OP_SRA, OP_SLA: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] phase_code(input seq_state_e s);
        logic [1:0] code;
        if (s == EXEC) begin
            code = 2'd2;
        end else begin
            code = s[1:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces one raw active-low button and
// emits a single-cycle pulse when the debounced level goes from released to
// pressed. Release produces no pulse; a held button produces exactly one.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   btn_n_raw   - raw, bouncy, active-low button input
//   press_pulse - one-cycle press event
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_raw,
    output logic press_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive synchronized samples that disagree with the accepted
    // level; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
                pulse_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            cnt_q       <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1_q     <= btn_n_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            press_pulse <= pulse_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: switch-entry front end for the board ALU. Successive enter
// presses capture operand A, operand B and then opcode + carry-in; the ALU is
// driven from these registers, and one cycle later its result and flags are
// latched for display. A clear press returns to GET_A from any state.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   data_sw, op_sw      - operand and opcode switches
//   cin_sw              - carry-in switch
//   enter_btn_n         - raw active-low enter button
//   clear_btn_n         - raw active-low clear button
//   alu_a, alu_b        - registered operands to the ALU
//   alu_sel_n, alu_cin  - registered inverted opcode and carry-in to the ALU
//   alu_result, alu_*   - ALU result and flags
//   res_q, flags_q      - latched result and flags {ovf,cout,zero,neg}
//   res_valid           - high while the result is shown
//   phase               - LED state code
//   err_q               - last opcode entry was invalid
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_sw,
    input  logic [3:0]   op_sw,
    input  logic         cin_sw,
    input  logic         enter_btn_n,
    input  logic         clear_btn_n,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel_n,
    output logic         alu_cin,
    input  logic [N-1:0] alu_result,
    input  logic         alu_neg,
    input  logic         alu_zero,
    input  logic         alu_cout,
    input  logic         alu_ovf,
    output logic [N-1:0] res_q,
    output logic [3:0]   flags_q,
    output logic         res_valid,
    output logic [1:0]   phase,
    output logic         err_q
);

    logic enter_pulse;
    logic clear_pulse;

    seq_state_e   state_q, state_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [3:0]   sel_n_q, sel_n_d;
    logic         cin_q, cin_d;
    logic [N-1:0] res_d;
    logic [3:0]   flags_d;
    logic         err_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n_raw  (enter_btn_n),
        .press_pulse(enter_pulse)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n_raw  (clear_btn_n),
        .press_pulse(clear_pulse)
    );

    always_comb begin
        state_d = state_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        sel_n_d = sel_n_q;
        cin_d   = cin_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;

        if (clear_pulse) begin
            // Clear overrides any enter pulse landing in the same cycle.
            state_d = GET_A;
            alu_a_d = '0;
            alu_b_d = '0;
            sel_n_d = ~OP_ADD;
            cin_d   = 1'b0;
            res_d   = '0;
            flags_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (enter_pulse) begin
                        alu_a_d = data_sw;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (enter_pulse) begin
                        alu_b_d = data_sw;
                        state_d = GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter_pulse) begin
                        if (op_is_valid(op_sw)) begin
                            sel_n_d = ~op_sw;
                            cin_d   = cin_sw;
                            err_d   = 1'b0;
                            state_d = EXEC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // ALU inputs have had a full cycle to settle; enter is ignored here.
                    res_d             = alu_result;
                    flags_d[FLG_NEG]  = alu_neg;
                    flags_d[FLG_ZERO] = alu_zero;
                    flags_d[FLG_COUT] = alu_cout;
                    flags_d[FLG_OVF]  = alu_ovf;
                    state_d           = SHOW;
                end
                SHOW: begin
                    if (enter_pulse) begin
                        state_d = GET_A;
                    end
                end
                default: state_d = GET_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GET_A;
            alu_a_q <= '0;
            alu_b_q <= '0;
            sel_n_q <= ~OP_ADD;
            cin_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            sel_n_q <= sel_n_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel_n = sel_n_q;
    assign alu_cin   = cin_q;
    assign res_valid = (state_q == SHOW);
    assign phase     = phase_code(state_q);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int N  = 4;
    localparam int DB = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] data_sw = '0;
    logic [3:0]   op_sw = '0;
    logic         cin_sw = 1'b0;
    logic         enter_btn_n = 1'b1;
    logic         clear_btn_n = 1'b1;
    logic [N-1:0] alu_a, alu_b, alu_result, res_q;
    logic [3:0]   alu_sel_n, flags_q;
    logic         alu_cin, alu_neg, alu_zero, alu_cout, alu_ovf;
    logic         res_valid, err_q;
    logic [1:0]   phase;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .N              (N),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_sw    (data_sw),
        .op_sw      (op_sw),
        .cin_sw     (cin_sw),
        .enter_btn_n(enter_btn_n),
        .clear_btn_n(clear_btn_n),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel_n  (alu_sel_n),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_neg    (alu_neg),
        .alu_zero   (alu_zero),
        .alu_cout   (alu_cout),
        .alu_ovf    (alu_ovf),
        .res_q      (res_q),
        .flags_q    (flags_q),
        .res_valid  (res_valid),
        .phase      (phase),
        .err_q      (err_q)
    );

    // Behavioural ALU model driven by the sequencer's registered outputs.
    always_comb begin
        logic [3:0] op;
        logic [N:0] sum;
        op       = ~alu_sel_n;
        sum      = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            4'd0: begin
                sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
                alu_cout = sum[N];
                alu_ovf  = (alu_a[N-1] == alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
            end
            4'd1: begin
                sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
                alu_cout = sum[N];
                alu_ovf  = (alu_a[N-1] != alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
            end
            4'd2:    sum[N-1:0] = ~alu_a;
            4'd3:    sum[N-1:0] = alu_a & alu_b;
            4'd4:    sum[N-1:0] = alu_a | alu_b;
            4'd5:    sum[N-1:0] = alu_a ^ alu_b;
            4'd6:    sum[N-1:0] = alu_a >> alu_b;
            4'd7:    sum[N-1:0] = alu_a << alu_b;
            4'd8:    sum[N-1:0] = $signed(alu_a) >>> alu_b;
            4'd9:    sum[N-1:0] = alu_a << alu_b;
            default: sum = '0;
        endcase
        alu_result = sum[N-1:0];
        alu_zero   = (sum[N-1:0] == '0);
        alu_neg    = sum[N-1];
    end

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flags;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulse_cyc = -100;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected result on each rising edge of res_valid.
    always @(negedge clk) begin
        if (dut.enter_pulse && phase == 2'd2) pulse_cyc = cyc;
        if (res_valid && !valid_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(res_q), 32'hdead);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_res"}, 32'(res_q), 32'(e.res));
                check({e.name, "_flags"}, 32'(flags_q), 32'(e.flags));
                check({e.name, "_latency"}, 32'(cyc - pulse_cyc), 32'd2);
            end
        end
        valid_prev = res_valid;
    end

    task automatic press(input int hold);
        @(negedge clk) enter_btn_n = 1'b0;
        repeat (hold) @(negedge clk);
        enter_btn_n = 1'b1;
        repeat (3 * DB) @(negedge clk);
    endtask

    task automatic push(input logic [N-1:0] r, input logic [3:0] f, input string name);
        exp_t e;
        e.res   = r;
        e.flags = f;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check("rst_sel_n", 32'(alu_sel_n), 32'hf);
        check("rst_cin", 32'(alu_cin), 32'd0);
        check("rst_res", 32'(res_q), 32'd0);
        check("rst_flags", 32'(flags_q), 32'd0);
        check("rst_err", 32'(err_q), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Add: 0001 + 1010 + 1 = 1100, flags {ovf,cout,zero,neg} = 0001.
        data_sw = 4'b0001;
        press(3 * DB);
        check("add_phase_b", 32'(phase), 32'd1);
        check("add_a", 32'(alu_a), 32'b0001);
        data_sw = 4'b1010;
        press(3 * DB);
        check("add_a_held", 32'(alu_a), 32'b0001);
        check("add_b", 32'(alu_b), 32'b1010);
        check("add_phase_op", 32'(phase), 32'd2);
        op_sw  = 4'b0000;
        cin_sw = 1'b1;
        push(4'b1100, 4'b0001, "add");
        press(3 * DB);
        check("add_sel_n", 32'(alu_sel_n), 32'b1111);
        check("add_cin", 32'(alu_cin), 32'd1);
        check("add_show", 32'(phase), 32'd3);
        check("add_valid", 32'(res_valid), 32'd1);
        press(3 * DB);
        check("show_to_a", 32'(phase), 32'd0);
        check("res_hold", 32'(res_q), 32'b1100);

        // Shift: 1011 >>> 1 = 1101, flags 0001.
        data_sw = 4'b1011;
        press(3 * DB);
        data_sw = 4'b0001;
        press(3 * DB);
        op_sw  = 4'b1000;
        cin_sw = 1'b0;
        push(4'b1101, 4'b0001, "sra");
        press(3 * DB);
        check("sra_sel_n", 32'(alu_sel_n), 32'b0111);
        check("sra_phase", 32'(phase), 32'd3);
        press(3 * DB);

        // Invalid opcode then AND: 0110 & 0011 = 0010, flags 0000.
        data_sw = 4'b0110;
        press(3 * DB);
        data_sw = 4'b0011;
        press(3 * DB);
        op_sw = 4'b1100;
        press(3 * DB);
        check("inv_err", 32'(err_q), 32'd1);
        check("inv_phase", 32'(phase), 32'd2);
        check("inv_sel_n", 32'(alu_sel_n), 32'b0111);
        op_sw = 4'b0011;
        push(4'b0010, 4'b0000, "and");
        press(3 * DB);
        check("and_err", 32'(err_q), 32'd0);
        check("and_phase", 32'(phase), 32'd3);
        press(3 * DB);

        // Bounce rejection: five short lows must not register.
        data_sw = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) enter_btn_n = 1'b0;
            repeat (DB - 2) @(negedge clk);
            enter_btn_n = 1'b1;
            repeat (DB) @(negedge clk);
        end
        repeat (2 * DB) @(negedge clk);
        check("bounce_phase", 32'(phase), 32'd0);
        check("bounce_a", 32'(alu_a), 32'b0110);
        data_sw = 4'b0101;
        press(40);
        check("hold_phase", 32'(phase), 32'd1);
        check("hold_a", 32'(alu_a), 32'b0101);

        // Clear priority over a coincident enter, with err set beforehand.
        data_sw = 4'b0111;
        press(3 * DB);
        op_sw = 4'b1111;
        press(3 * DB);
        check("pre_clr_err", 32'(err_q), 32'd1);
        @(negedge clk);
        enter_btn_n = 1'b0;
        clear_btn_n = 1'b0;
        repeat (40) @(negedge clk);
        enter_btn_n = 1'b1;
        clear_btn_n = 1'b1;
        repeat (3 * DB) @(negedge clk);
        check("clr_phase", 32'(phase), 32'd0);
        check("clr_a", 32'(alu_a), 32'd0);
        check("clr_b", 32'(alu_b), 32'd0);
        check("clr_err", 32'(err_q), 32'd0);
        check("clr_res", 32'(res_q), 32'd0);

        // Async reset while in SHOW: 0010 + 0011 = 0101, flags 0000.
        data_sw = 4'b0010;
        press(3 * DB);
        data_sw = 4'b0011;
        press(3 * DB);
        op_sw = 4'b0000;
        push(4'b0101, 4'b0000, "add2");
        press(3 * DB);
        check("ar_pre_phase", 32'(phase), 32'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_phase", 32'(phase), 32'd0);
        check("ar_a", 32'(alu_a), 32'd0);
        check("ar_b", 32'(alu_b), 32'd0);
        check("ar_sel_n", 32'(alu_sel_n), 32'hf);
        check("ar_res", 32'(res_q), 32'd0);
        check("ar_flags", 32'(flags_q), 32'd0);
        check("ar_valid", 32'(res_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        data_sw = 4'b1001;
        press(3 * DB);
        check("post_rst_phase", 32'(phase), 32'd1);
        check("post_rst_a", 32'(alu_a), 32'b1001);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
